// File: rtl/xge_tx_pkg.sv
// Shared types for the XGE transmit feeder.
//   MOD_FULL   : mod encoding for "all 8 bytes valid"
//   tx_entry_t : one stored FIFO word {data, last, mod}
//   wr_state_t : host-side write FSM states
//   rd_state_t : MAC-side read FSM states
package xge_tx_pkg;

  localparam logic [2:0] MOD_FULL = 3'd0;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [2:0]  mod;
  } tx_entry_t;

  typedef enum logic {
    WR_ACCEPT = 1'b0,
    WR_DROP   = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_SEND = 1'b1
  } rd_state_t;

endpackage

// File: rtl/pkt_tx_fifo_ram.sv
// Simple dual-port storage for the transmit feeder.
//   clk         : clock
//   we/waddr/wdata : synchronous write port
//   re/raddr    : read request; rdata updates on the edge where re is high
//   rdata       : registered read data, holds its value while re is low
module pkt_tx_fifo_ram
  import xge_tx_pkg::*;
#(
  parameter int DEPTH = 512,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  tx_entry_t     wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output tx_entry_t     rdata
);

  tx_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pkt_tx_feeder.sv
// Store-and-forward staging buffer in front of the XGE MAC transmit port.
// Host words are written as they arrive; a packet becomes visible to the
// read side only once its last word is committed. Oversize packets are
// rewound out of the FIFO and counted.
//   clk_156m25, reset_156m25_n : clock, async active-low reset
//   s_data/s_valid/s_ready/s_last/s_mod : host word stream
//   pkt_tx_data/sop/eop/mod/val : registered MAC transmit interface
//   pkt_tx_full : MAC backpressure, acts on the edge it is sampled
//   drop_cnt    : saturating count of oversize packets dropped
//   level       : words stored (committed + uncommitted + in flight to MAC)
module pkt_tx_feeder
  import xge_tx_pkg::*;
#(
  parameter int DEPTH         = 512,
  parameter int MAX_PKT_WORDS = 200
) (
  input  logic                    clk_156m25,
  input  logic                    reset_156m25_n,
  input  logic [63:0]             s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_last,
  input  logic [2:0]              s_mod,
  output logic [63:0]             pkt_tx_data,
  output logic                    pkt_tx_sop,
  output logic                    pkt_tx_eop,
  output logic [2:0]              pkt_tx_mod,
  output logic                    pkt_tx_val,
  input  logic                    pkt_tx_full,
  output logic [15:0]             drop_cnt,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WCW = $clog2(MAX_PKT_WORDS + 1);
  localparam logic [AW:0]  DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [WCW:0] MAX_W   = (WCW+1)'(MAX_PKT_WORDS);

  // ---------------- write side ----------------
  wr_state_t      wst, wst_n;
  logic [AW:0]    wr_ptr, wr_ptr_n, commit_ptr, commit_n, rd_ptr;
  logic [WCW-1:0] wcnt, wcnt_n;
  logic [WCW:0]   wcnt_inc;
  logic [15:0]    drop_n;
  logic           xfer, oversize, we, dropping;
  tx_entry_t      wentry;

  assign xfer     = s_valid & s_ready;
  assign wcnt_inc = {1'b0, wcnt} + 1'b1;
  assign oversize = wcnt_inc > MAX_W;
  assign wentry   = '{data: s_data, last: s_last, mod: s_last ? s_mod : MOD_FULL};

  always_comb begin
    wst_n    = wst;
    wr_ptr_n = wr_ptr;
    commit_n = commit_ptr;
    wcnt_n   = wcnt;
    drop_n   = drop_cnt;
    we       = 1'b0;
    dropping = 1'b0;
    if (xfer) begin
      if (wst == WR_ACCEPT) begin
        if (oversize) begin
          // Throw away everything written for this packet.
          dropping = 1'b1;
          wr_ptr_n = commit_ptr;
          wcnt_n   = '0;
          if (drop_cnt != 16'hFFFF) drop_n = drop_cnt + 16'd1;
          if (!s_last) wst_n = WR_DROP;
        end else begin
          we       = 1'b1;
          wr_ptr_n = wr_ptr + 1'b1;
          if (s_last) begin
            commit_n = wr_ptr + 1'b1;
            wcnt_n   = '0;
          end else begin
            wcnt_n = wcnt_inc[WCW-1:0];
          end
        end
      end else if (s_last) begin
        wst_n  = WR_ACCEPT;
        wcnt_n = '0;
      end
    end
  end

  // ---------------- read side ----------------
  // The RAM output register doubles as a one-entry prefetch: rvalid says it
  // holds the entry at rd_ptr. It may prefetch uncommitted words so the
  // first word of a packet is ready as soon as the commit lands.
  rd_state_t   rst_q;
  tx_entry_t   rdata;
  logic        rvalid, rvalid_n, consume, re;
  logic [AW:0] raddr, rd_ptr_n;

  assign consume  = rvalid && (rd_ptr != commit_ptr) && !pkt_tx_full;
  assign raddr    = consume ? rd_ptr + 1'b1 : rd_ptr;
  assign re       = (!rvalid || consume) && (raddr != wr_ptr);
  assign rd_ptr_n = consume ? rd_ptr + 1'b1 : rd_ptr;

  always_comb begin
    rvalid_n = re || (rvalid && !consume);
    // A prefetched word of a packet being dropped must not survive.
    if (dropping && raddr == commit_ptr) rvalid_n = 1'b0;
  end

  pkt_tx_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk_156m25),
    .we    (we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wentry),
    .re    (re),
    .raddr (raddr[AW-1:0]),
    .rdata (rdata)
  );

  assign level = wr_ptr - rd_ptr;

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      wst         <= WR_ACCEPT;
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      rd_ptr      <= '0;
      wcnt        <= '0;
      drop_cnt    <= '0;
      s_ready     <= 1'b0;
      rvalid      <= 1'b0;
      rst_q       <= RD_IDLE;
      pkt_tx_data <= '0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= MOD_FULL;
      pkt_tx_val  <= 1'b0;
    end else begin
      wst        <= wst_n;
      wr_ptr     <= wr_ptr_n;
      commit_ptr <= commit_n;
      rd_ptr     <= rd_ptr_n;
      wcnt       <= wcnt_n;
      drop_cnt   <= drop_n;
      rvalid     <= rvalid_n;
      // Registered ready: reflects the level after this edge, so a read in
      // the same cycle as a full FIFO only frees space for the next cycle.
      s_ready    <= (wst_n == WR_DROP) || ((wr_ptr_n - rd_ptr_n) != DEPTH_W);
      if (consume) begin
        pkt_tx_data <= rdata.data;
        pkt_tx_sop  <= (rst_q == RD_IDLE);
        pkt_tx_eop  <= rdata.last;
        pkt_tx_mod  <= rdata.last ? rdata.mod : MOD_FULL;
        pkt_tx_val  <= 1'b1;
        rst_q       <= rdata.last ? RD_IDLE : RD_SEND;
      end else begin
        pkt_tx_val  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pkt_tx_feeder.md
Name: pkt_tx_feeder

Overview:
- Store-and-forward staging buffer directly upstream of the XGE MAC transmit packet interface.
- Accepts a 64-bit valid/ready word stream from the host side and buffers complete packets.
- Replays each buffered packet onto pkt_tx_data/sop/eop/mod/val without intra-packet bubbles, except those forced by pkt_tx_full.
- Drops packets that exceed the maximum length and counts them.

Parameters:
- DEPTH, 512, FIFO depth in 64-bit words; power of two, at least 4.
- MAX_PKT_WORDS, 200, longest accepted packet in words; must be less than or equal to DEPTH.

Ports:
- clk_156m25 input 1: single clock domain.
- reset_156m25_n input 1: asynchronous, active-low reset.
- s_data input 64: host word; byte 0 on [63:56].
- s_valid input 1: host word valid.
- s_ready output 1: block accepts the word when s_valid and s_ready are both high.
- s_last input 1: last word of the packet.
- s_mod input 3: valid bytes in the last word; 0 means 8. Ignored when s_last is 0.
- pkt_tx_data output 64: word to the MAC.
- pkt_tx_sop output 1: first word of a packet.
- pkt_tx_eop output 1: last word of a packet.
- pkt_tx_mod output 3: valid bytes on eop; 0 means 8. Driven 0 when eop is 0.
- pkt_tx_val output 1: word valid to the MAC.
- pkt_tx_full input 1: MAC backpressure.
- drop_cnt output 16: count of oversize packets dropped; saturates at 0xFFFF.
- level output $clog2(DEPTH)+1: words currently stored, committed plus uncommitted.

Behaviour:
- Reset (asynchronous): all outputs 0, pointers 0, both FSMs to their idle state. A packet partially written or partially sent is discarded. s_ready is 0 during reset and 1 in the first cycle after reset.
- Storage: one entry per word = {data[63:0], last, mod[2:0]}. The block keeps wr_ptr, commit_ptr and rd_ptr, each $clog2(DEPTH)+1 bits wide with a wrap bit. level = wr_ptr - rd_ptr.
- Write FSM, states ACCEPT and DROP.
  - ACCEPT: s_ready = (level != DEPTH).
    - On a word transfer, increment a word counter (wcnt).
    - If s_last and wcnt+1 <= MAX_PKT_WORDS: write the entry and set commit_ptr = wr_ptr+1 in the same cycle.
    - If wcnt+1 > MAX_PKT_WORDS: do not write the word, rewind wr_ptr to commit_ptr, increment drop_cnt. Go to DROP, or stay in ACCEPT if this word has s_last set.
  - DROP: s_ready = 1. Discard words until a transfer with s_last, then go to ACCEPT with wcnt = 0.
  - A single-word packet (s_last on the first word) is legal.
- Read FSM, states IDLE and SEND. All pkt_tx_* outputs are registered. full_q is pkt_tx_full sampled at the current edge.
  - IDLE: if rd_ptr != commit_ptr and full_q == 0, present the entry at the next edge with sop=1 and val=1, then go to SEND. If that entry also has last=1, assert eop and mod as well, and stay in IDLE.
  - SEND: on each edge with full_q == 0, present the next entry with val=1. On the entry with last=1, drive eop=1 and mod=entry.mod, then return to IDLE.
  - If full_q == 1, val goes low and data/sop/eop/mod hold their values.
- Latency: a packet's first word can reach pkt_tx_val 2 cycles after its s_last transfer (1 cycle to commit, 1 registered output cycle).
- Back-to-back packets: eop of packet N may be followed by sop of packet N+1 in the next cycle.
- Simultaneous write and read in one cycle: level changes by the net amount. A full FIFO with a concurrent read does not assert s_ready in that cycle; s_ready uses the registered level.
- A packet that cannot fit because the FIFO is full while the read side is idle cannot deadlock: MAX_PKT_WORDS <= DEPTH, so the read side always drains committed data first.
- MAC full rule: pkt_tx_val is never high in a cycle that follows an edge where pkt_tx_full was sampled high.

Decomposition:
- Shared package xge_tx_pkg holds:
  - MOD_FULL = 3'd0.
  - typedef tx_entry_t with fields data, last, mod.
  - Write and read FSM state enums.
- One sub-module, pkt_tx_fifo_ram: simple dual-port RAM, synchronous write, registered read, DEPTH x 68 bits. The read FSM prefetches one entry to absorb the RAM read latency.

Test Plan:
- Single packet of 3 words, s_mod=5 on the last word, pkt_tx_full=0 -> 3 consecutive pkt_tx_val cycles, starting 2 cycles after s_last; sop on word 0, eop on word 2 with mod=5; drop_cnt=0.
- Two 1-word packets back to back -> each output cycle has sop=eop=1, and the second packet follows the first in the next cycle.
- pkt_tx_full held high for 4 cycles in the middle of an 8-word packet -> val low for exactly 4 cycles, data held, no word lost or duplicated, eop on the 8th word.
- Packet of MAX_PKT_WORDS+1 = 201 words followed by a 2-word packet -> drop_cnt=1; only the 2-word packet appears on the MAC side; level returns to 0.
- Fill to DEPTH with pkt_tx_full=1 -> s_ready=0 at level 512. Release full -> data drains and s_ready reasserts.
- Assert reset mid-SEND on the 4th of 6 words -> outputs 0 immediately; after release level=0, drop_cnt=0, and no eop is emitted for the aborted packet.
